// File: rtl/al_gsrn_seq.sv
// Global reset sequencer: holds gsrn low, then releases domain resets in stages.
// Optional per-bit request debounce with AL_GSRN_SEQ_DEBOUNCE_EN.
module al_gsrn_seq #(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 16,
    parameter int STAGES   = 3,
    parameter int GAP_CYC  = 4,
    parameter int DEB_CYC  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_i,
    input  logic              cause_clr_i,
    output logic              gsrn_o,
    output logic [STAGES-1:0] stage_rstn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [NREQ-1:0]   cause_o,
    output logic              por_o
);

    localparam int CMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {
        HOLD,
        REL,
        RUN
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [NREQ-1:0]   req_eff;
    logic              any_req;
    logic [STAGES-1:0] sr_nxt;

`ifdef AL_GSRN_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYC + 1);

    logic [DW-1:0] deb_cnt [NREQ];

    // Saturating run-length of high samples; any low sample restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_i[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DW'(DEB_CYC)) begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        req_eff = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_eff[i] = (deb_cnt[i] == DW'(DEB_CYC));
        end
    end
`else
    assign req_eff = req_i;
`endif

    assign any_req = |req_eff;
    assign sr_nxt  = (stage_rstn_o << 1) | STAGES'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= HOLD;
            cnt          <= '0;
            gsrn_o       <= 1'b0;
            stage_rstn_o <= '0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            cause_o      <= '0;
            por_o        <= 1'b1;
        end else begin
            done_o <= 1'b0;

            // A clear and a capture in one cycle: clear first, then OR in.
            if (any_req) begin
                cause_o <= (cause_clr_i ? '0 : cause_o) | req_eff;
                por_o   <= 1'b0;
            end else if (cause_clr_i) begin
                cause_o <= '0;
                por_o   <= 1'b0;
            end

            unique case (state)
                HOLD: begin
                    if (any_req) begin
                        cnt <= '0;
                    end else if (cnt == CW'(HOLD_CYC - 1)) begin
                        cnt    <= '0;
                        gsrn_o <= 1'b1;
                        state  <= REL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REL: begin
                    if (any_req) begin
                        cnt          <= '0;
                        gsrn_o       <= 1'b0;
                        stage_rstn_o <= '0;
                        state        <= HOLD;
                    end else if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt          <= '0;
                        stage_rstn_o <= sr_nxt;
                        if (&sr_nxt) begin
                            done_o <= 1'b1;
                            state  <= RUN;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (any_req) begin
                        cnt          <= '0;
                        gsrn_o       <= 1'b0;
                        stage_rstn_o <= '0;
                        busy_o       <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
